// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
// Execution-unit additions: result_t and exec_state_t.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  localparam int EXEC_RESULT_W = 64;

  typedef logic signed [EXEC_RESULT_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    OUT,
    DONE
  } exec_state_t;

endpackage

// File: rtl/instr_exec_unit_alu.sv
// Combinational ALU for the execution stage. The divider for DIV/MOD exists
// only when INSTR_EXEC_DIV_EN is defined; otherwise those opcodes raise err.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int RESULT_W = 64
) (
  input  opcode_t                     opc,
  input  operand_t                    op_a,
  input  operand_t                    op_b,
  output logic signed [RESULT_W-1:0]  result,
  output logic                        err
);

  logic signed [RESULT_W-1:0] a_ext;
  logic signed [RESULT_W-1:0] b_ext;

  // Operands widened first so sums, differences and products never wrap.
  assign a_ext = {{(RESULT_W-32){op_a[31]}}, op_a};
  assign b_ext = {{(RESULT_W-32){op_b[31]}}, op_b};

`ifdef INSTR_EXEC_DIV_EN
  logic signed [RESULT_W-1:0] divisor;
  logic signed [RESULT_W-1:0] quot;
  logic signed [RESULT_W-1:0] rem;

  // Substitute divisor keeps the divider free of divide-by-zero; err masks it.
  assign divisor = (op_b == '0) ? {{(RESULT_W-1){1'b0}}, 1'b1} : b_ext;
  assign quot    = a_ext / divisor;
  assign rem     = a_ext % divisor;
`endif

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (opc)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV, MOD: begin
`ifdef INSTR_EXEC_DIV_EN
        if (op_b == '0) begin
          err = 1'b1;
        end else begin
          result = (opc == DIV) ? quot : rem;
        end
`else
        err = 1'b1;
`endif
      end
      default: begin
        result = '0;
        err    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a window of instruction-register locations, executes
// each word and hands results downstream over valid/ready. Macro: INSTR_EXEC_DIV_EN.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int RESULT_W = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  address_t                    base_addr,
  input  logic [5:0]                  count,
  output address_t                    read_pointer,
  input  instruction_t                instruction_word,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [RESULT_W-1:0]  res_data,
  output address_t                    res_addr,
  output opcode_t                     res_opc,
  output logic                        err,
  output logic                        done
);

  exec_state_t                state_q;
  address_t                   rp_q;
  logic [5:0]                 remaining_q;
  logic                       busy_q;
  logic                       valid_q;
  logic signed [RESULT_W-1:0] data_q;
  address_t                   addr_q;
  opcode_t                    res_opc_q;
  logic                       err_q;
  logic                       done_q;

  opcode_t                    op_opc_q;
  operand_t                   op_a_q;
  operand_t                   op_b_q;

  logic signed [RESULT_W-1:0] alu_result;
  logic                       alu_err;

  // The stored result field of the instruction word plays no part in execution.
  logic                       unused_result;
  assign unused_result = ^instruction_word.result;

  // Operand registers are pure data: loaded in FETCH, never reset.
  always_ff @(posedge clk) begin
    if (state_q == FETCH) begin
      op_opc_q <= instruction_word.opc;
      op_a_q   <= instruction_word.op_a;
      op_b_q   <= instruction_word.op_b;
    end
  end

  instr_alu #(
    .RESULT_W(RESULT_W)
  ) u_alu (
    .opc    (op_opc_q),
    .op_a   (op_a_q),
    .op_b   (op_b_q),
    .result (alu_result),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rp_q        <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      res_opc_q   <= ZERO;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            remaining_q <= count;
            if (count == 6'd0) begin
              state_q <= DONE;
            end else begin
              rp_q    <= base_addr;
              state_q <= FETCH;
            end
          end
        end
        FETCH: state_q <= EXEC;
        EXEC: begin
          data_q    <= alu_result;
          res_opc_q <= op_opc_q;
          err_q     <= alu_err;
          addr_q    <= rp_q;
          valid_q   <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          // Result and read pointer stay frozen until the consumer takes it.
          if (res_ready) begin
            valid_q     <= 1'b0;
            remaining_q <= remaining_q - 6'd1;
            if (remaining_q > 6'd1) begin
              rp_q    <= rp_q + 5'd1;
              state_q <= FETCH;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_pointer = rp_q;
  assign busy         = busy_q;
  assign res_valid    = valid_q;
  assign res_data     = data_q;
  assign res_addr     = addr_q;
  assign res_opc      = res_opc_q;
  assign err          = err_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed, table-driven bench for instr_exec_unit with a combinational
// instruction-register model behind read_pointer.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  localparam int RW = 64;
`ifdef INSTR_EXEC_DIV_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  address_t              base_addr;
  logic [5:0]            count;
  address_t              read_pointer;
  instruction_t          instruction_word;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic signed [RW-1:0]  res_data;
  address_t              res_addr;
  opcode_t               res_opc;
  logic                  err;
  logic                  done;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  always #5 clk = ~clk;

  instr_exec_unit #(.RESULT_W(RW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_addr         (res_addr),
    .res_opc          (res_opc),
    .err              (err),
    .done             (done)
  );

  typedef struct {
    opcode_t opc;
    int      a;
    int      b;
    longint  exp;
    bit      e;
  } vec_t;

  vec_t    tbl [12];
  longint  exp_data [32];
  bit      exp_err  [32];
  int      exp_addr [32];
  opcode_t exp_opc  [32];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic load(input int base, input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int loc;
      loc = (base + i) % 32;
      mem[loc].opc    = tbl[first+i].opc;
      mem[loc].op_a   = tbl[first+i].a;
      mem[loc].op_b   = tbl[first+i].b;
      mem[loc].result = 64'h0BAD_0BAD_0BAD_0BAD;
      exp_data[i] = tbl[first+i].exp;
      exp_err[i]  = tbl[first+i].e;
      exp_addr[i] = loc;
      exp_opc[i]  = tbl[first+i].opc;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_rp"},        read_pointer, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"},  res_data, 0);
    chk({tag, "_res_addr"},  res_addr, 0);
    chk({tag, "_res_opc"},   res_opc, ZERO);
    chk({tag, "_err"},       err, 0);
    chk({tag, "_done"},      done, 0);
  endtask

  // Start a run with res_ready high, check every result and the done timing.
  task automatic run_seq(input string tag, input int base, input int cnt, input bit poke);
    int nres;
    int done_k;
    int first_k;
    @(negedge clk);
    start = 1'b1; base_addr = address_t'(base); count = 6'(cnt); res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; base_addr = 5'd17; count = 6'd9;
    if (cnt > 0) chk({tag, "_rp_after_start"}, read_pointer, base);
    chk({tag, "_busy_after_start"}, busy, 1);
    nres = 0; done_k = -1; first_k = -1;
    for (int k = 1; k <= 3 * cnt + 12; k++) begin
      if (poke && k == 4) begin
        start = 1'b1; base_addr = 5'd20; count = 6'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (res_valid) begin
        if (first_k < 0) first_k = k;
        if (nres < cnt) begin
          chk($sformatf("%s_data%0d", tag, nres), res_data, exp_data[nres]);
          chk($sformatf("%s_err%0d", tag, nres), err, exp_err[nres]);
          chk($sformatf("%s_addr%0d", tag, nres), res_addr, exp_addr[nres]);
          chk($sformatf("%s_opc%0d", tag, nres), res_opc, exp_opc[nres]);
        end
        nres++;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
    if (cnt > 0) chk({tag, "_first_valid_cycle"}, first_k, 2);
    chk({tag, "_result_count"}, nres, cnt);
    chk({tag, "_done_cycle"}, done_k, 3 * cnt + 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tbl[0]  = '{ADD,   5,  3, 8, 0};
    tbl[1]  = '{SUB,   2,  7, -5, 0};
    tbl[2]  = '{MULT, -4,  6, -24, 0};
    tbl[3]  = '{ZERO,  9,  9, 0, 0};
    tbl[4]  = '{PASSA, -123, 4, -123, 0};
    tbl[5]  = '{PASSB, 1, -77, -77, 0};
    tbl[6]  = '{MULT, 2147483647, 2147483647, 64'sd4611686014132420609, 0};
    tbl[7]  = '{ADD,  2147483647, 1, 64'sd2147483648, 0};
    tbl[8]  = '{SUB,  int'(32'h8000_0000), 1, -64'sd2147483649, 0};
    tbl[9]  = '{DIV,  -7, 2, DIVEN ? -3 : 0, !DIVEN};
    tbl[10] = '{MOD,  -7, 2, DIVEN ? -1 : 0, !DIVEN};
    tbl[11] = '{DIV,   5, 0, 0, 1};

    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;

    load(0, 0, 3);
    run_seq("basic", 0, 3, 1'b0);

    load(0, 0, 12);
    run_seq("table", 0, 12, 1'b0);

    load(30, 3, 4);
    run_seq("wrap", 30, 4, 1'b0);

    run_seq("count0", 7, 0, 1'b0);

    load(0, 0, 2);
    run_seq("busy_start", 0, 2, 1'b1);

    // Backpressure: first result must hold for 4 cycles with res_ready low.
    load(0, 0, 2);
    @(negedge clk);
    start = 1'b1; base_addr = 5'd0; count = 6'd2; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !res_valid; k++) @(negedge clk);
    chk("bp_valid_seen", res_valid, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), res_valid, 1);
      chk($sformatf("bp_hold_data%0d", k), res_data, 8);
      chk($sformatf("bp_hold_addr%0d", k), res_addr, 0);
      chk($sformatf("bp_hold_rp%0d", k), read_pointer, 0);
      chk($sformatf("bp_hold_opc%0d", k), res_opc, ADD);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_dropped", res_valid, 0);
    chk("bp_rp_advanced", read_pointer, 1);
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (res_valid) begin
        seen++;
        chk("bp_second_data", res_data, -5);
      end
    end
    chk("bp_second_seen", seen, 1);
    chk("bp_done", done, 1);

    // Reset while a result is pending in OUT.
    load(0, 0, 3);
    @(negedge clk);
    start = 1'b1; base_addr = 5'd0; count = 6'd3; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && !res_valid; k++) @(negedge clk);
    chk("rst_out_valid_seen", res_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst_out");
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy || res_valid) seen++;
    end
    chk("rst_out_quiet", seen, 0);
    run_seq("after_rst", 0, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, required finish");
    $fatal(1);
  end

endmodule
